sequential_left_shift_32_bit: RTL and testbench
===============================================

# sequential_left_shift_32_bit

Multi-cycle 32-bit logical left shifter for the ALU datapath. It is the left-shift counterpart to the combinational right-shift barrel shifter. Instead of five parallel mux layers, it applies one power-of-two shift stage per clock: shifts of 1, 2, 4, 8 and 16 bits, each gated by the matching shift-amount bit. A start/done handshake hands the result back to the ALU control sequencer.

## Interface
- Parameters: none. Data width is fixed at 32 and shift amount at 5 bits.
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when `busy` = 0
- dta  input  32  operand, captured on the accepting edge
- L  input  5  shift amount 0–31, captured on the accepting edge
- out  output  32  shift register contents; final result is valid while `done` = 1
- busy  output  1  high while a shift is in progress
- done  output  1  one-cycle pulse marking `out` valid
- ovf  output  1  signed-overflow flag; present only with SHL_OVF_EN

## Operation
- FSM states: IDLE, SHIFT, DONE. Stage counter `stg` is 3 bits, range 0–4.
- **IDLE:**
  - `start` = 1: load the register from `dta` and the amount latch from `L`, set `stg` = 0, go to SHIFT.
  - Otherwise hold `out`.
- **SHIFT, each edge:**
  - If latched `L[stg]` = 1, `out <= out << (1 << stg)` with zero fill on the right. Bits past bit 31 are discarded.
  - If latched `L[stg]` = 0, `out` holds.
  - If `stg` = 4, go to DONE; otherwise `stg` increments.
- **DONE:**
  - `done` = 1 for exactly this cycle.
  - `start` = 1: accept a new operation exactly as IDLE does, going back-to-back to SHIFT.
  - Otherwise go to IDLE.
- `busy` = 1 in SHIFT only. `done` = 1 in DONE only.
- `start` during SHIFT is ignored. The operation in flight is unaffected, and the ignored request is not queued.
- The module latches `dta` and `L` at acceptance. Input changes during SHIFT have no effect.
- L = 0 still takes all five stage cycles; the result equals `dta`.
- Reset, at any time including mid-operation:
  - state → IDLE, `stg` = 0;
  - `out` = 32'h0, `busy` = 0, `done` = 0, `ovf` = 0;
  - the operation in progress is abandoned with no `done` pulse.

## Timing
- Edge E0 accepts `start`. E1–E5 apply stages 0–4. `done` is high in the cycle after E5.
- Latency from the accepting edge to `done` is 5 cycles.
- Throughput is one operation per 6 cycles, with `start` asserted while in DONE.
- `out` changes only at stage edges or on load. It holds its value after DONE until the next accept.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.
- Simultaneous reset and `start`: reset wins.

## Configuration
- **SHL_OVF_EN defined:**
  - Adds output `ovf`, cleared at each accept.
  - At each active stage with shift s, `ovf` becomes sticky-set if bits [31:31-s] of `out` before that stage are not all equal.
  - The final `ovf` is 1 iff `dta`·2^L does not fit in a signed 32-bit value.
  - `ovf` is valid with `done` and held afterward.
- **SHL_OVF_EN undefined:** no `ovf` port and no overflow logic. All other behaviour is identical.

## Test plan
- Reset mid-shift: accept `dta` = 32'hFFFF_FFFF, `L` = 31, assert `reset` after E2 → next cycle `out` = 0, `busy` = 0, `done` = 0. No `done` pulse follows.
- Basic shift: `dta` = 32'h0000_0001, `L` = 5'd31 → `busy` high for 5 cycles, `done` after E5, `out` = 32'h8000_0000.
- Zero shift and discard:
  - `dta` = 32'h1234_5678, `L` = 0 → `out` = 32'h1234_5678, 5-cycle latency.
  - Then `dta` = 32'hF000_000F, `L` = 4 → `out` = 32'h0000_00F0.
- Ignored start: assert `start` with `dta` = 32'hDEAD_BEEF during SHIFT of a (32'h3, `L` = 2) operation → `out` = 32'hC. Exactly one `done` pulse, and no second operation starts.
- Back-to-back: assert `start` in the DONE cycle with (32'h1, `L` = 16) → second `done` exactly 6 cycles after the first, `out` = 32'h0001_0000.
- SHL_OVF_EN:
  - 32'h4000_0000, `L` = 1 → `ovf` = 1.
  - 32'hC000_0000, `L` = 1 → `ovf` = 0.
  - 32'h0000_0001, `L` = 30 → `ovf` = 0.
  - 32'h0000_0001, `L` = 31 → `ovf` = 1.

Source files
------------

// File: rtl/sequential_left_shift_32_bit.sv
// Multi-cycle 32-bit logical left shifter: one power-of-two stage per clock, done 5 cycles after accept.
// start is ignored (not queued) while busy; optional signed-overflow flag when SHL_OVF_EN is defined.
module sequential_left_shift_32_bit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dta,
    input  logic [4:0]  L,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
`ifdef SHL_OVF_EN
    ,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_stg;
    logic [4:0]  r_amt;
    logic [31:0] r_out;
    logic        r_busy;
    logic        r_done;

    logic [7:0]  w_amt_ext;
    logic        w_stage_en;
    logic [31:0] w_shifted;

    assign w_amt_ext  = {3'b000, r_amt};
    assign w_stage_en = w_amt_ext[r_stg];

    always_comb begin
        w_shifted = r_out;
        case (r_stg)
            3'd0:    w_shifted = {r_out[30:0], 1'b0};
            3'd1:    w_shifted = {r_out[29:0], 2'b00};
            3'd2:    w_shifted = {r_out[27:0], 4'h0};
            3'd3:    w_shifted = {r_out[23:0], 8'h00};
            3'd4:    w_shifted = {r_out[15:0], 16'h0000};
            default: w_shifted = r_out;
        endcase
    end

`ifdef SHL_OVF_EN
    logic r_ovf;
    logic w_top_mixed;

    // A shift by s preserves the signed value only if the top s+1 bits agree.
    always_comb begin
        w_top_mixed = 1'b0;
        case (r_stg)
            3'd0:    w_top_mixed = r_out[31] ^ r_out[30];
            3'd1:    w_top_mixed = !((&r_out[31:29]) || (~|r_out[31:29]));
            3'd2:    w_top_mixed = !((&r_out[31:27]) || (~|r_out[31:27]));
            3'd3:    w_top_mixed = !((&r_out[31:23]) || (~|r_out[31:23]));
            3'd4:    w_top_mixed = !((&r_out[31:15]) || (~|r_out[31:15]));
            default: w_top_mixed = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_stg   <= 3'd0;
            r_amt   <= 5'd0;
            r_out   <= 32'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SHL_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_SHIFT;
                        r_out   <= dta;
                        r_amt   <= L;
                        r_stg   <= 3'd0;
                        r_busy  <= 1'b1;
`ifdef SHL_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (w_stage_en) begin
                        r_out <= w_shifted;
`ifdef SHL_OVF_EN
                        if (w_top_mixed) begin
                            r_ovf <= 1'b1;
                        end
`endif
                    end
                    if (r_stg == 3'd4) begin
                        r_state <= ST_DONE;
                        r_stg   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_stg   <= r_stg + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_stg   <= 3'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;
`ifdef SHL_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_sequential_left_shift_32_bit.sv
// Directed bench for sequential_left_shift_32_bit; overflow cases are built when SHL_OVF_EN is defined.
module tb_sequential_left_shift_32_bit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] dta;
    logic [4:0]  L;
    logic [31:0] out;
    logic        busy;
    logic        done;
`ifdef SHL_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    sequential_left_shift_32_bit dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .dta   (dta),
        .L     (L),
        .out   (out),
        .busy  (busy),
        .done  (done)
`ifdef SHL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present a request at the negedge; return 1ns after the accepting edge E0.
    task automatic start_op(input logic [31:0] d, input logic [4:0] amt);
        @(negedge clock);
        start = 1'b1;
        dta   = d;
        L     = amt;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (bounded); returns 99 on timeout.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        if (done !== 1'b1) cycles = 99;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dta   = 32'h0;
        L     = 5'd0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want %h", out, 32'h0); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
`ifdef SHL_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int busy_cycles;
        int n;
        start_op(32'h0000_0001, 5'd31);
        busy_cycles = 0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) busy_cycles++;
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (n !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", n); end
        checks++;
        if (busy_cycles !== 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 5", busy_cycles); end
        checks++;
        if (out !== 32'h8000_0000) begin errors++; $display("FAIL basic_out: got %h want %h", out, 32'h8000_0000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
        @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b0 || out !== 32'h8000_0000) begin
            errors++; $display("FAIL basic_hold: got done=%b out=%h want 0 80000000", done, out);
        end
    endtask

    task automatic test_zero_and_discard();
        int n;
        start_op(32'h1234_5678, 5'd0);
        wait_done(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL zero_latency: got %0d want 5", n); end
        checks++;
        if (out !== 32'h1234_5678) begin errors++; $display("FAIL zero_out: got %h want %h", out, 32'h1234_5678); end
        @(posedge clock);
        #1;
        start_op(32'hF000_000F, 5'd4);
        wait_done(n);
        checks++;
        if (out !== 32'h0000_00F0) begin errors++; $display("FAIL discard_out: got %h want %h", out, 32'h0000_00F0); end
    endtask

    task automatic test_ignored_start();
        int n;
        int extra;
        start_op(32'h0000_0003, 5'd2);
        @(negedge clock);
        start = 1'b1;
        dta   = 32'hDEAD_BEEF;
        L     = 5'd31;
        repeat (2) @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_done(n);
        checks++;
        if (out !== 32'h0000_000C) begin errors++; $display("FAIL ignored_out: got %h want %h", out, 32'h0000_000C); end
        extra = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ignored_no_second_op: got %0d active cycles want 0", extra); end
        checks++;
        if (out !== 32'h0000_000C) begin errors++; $display("FAIL ignored_hold: got %h want %h", out, 32'h0000_000C); end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(32'h0000_0005, 5'd3);
        wait_done(n);
        checks++;
        if (out !== 32'h0000_0028) begin errors++; $display("FAIL b2b_first_out: got %h want %h", out, 32'h0000_0028); end
        start_op(32'h0000_0001, 5'd16);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_accept_in_done: got busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(n);
        checks++;
        if (n + 1 !== 6) begin errors++; $display("FAIL b2b_spacing: got %0d want 6", n + 1); end
        checks++;
        if (out !== 32'h0001_0000) begin errors++; $display("FAIL b2b_out: got %h want %h", out, 32'h0001_0000); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        start_op(32'hFFFF_FFFF, 5'd31);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_state: got out=%h busy=%b done=%b want 0 0 0", out, busy, done);
        end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1 || out !== 32'h0) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d bad cycles want 0", seen); end
    endtask

    task automatic test_reset_vs_start();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        dta   = 32'h0000_00FF;
        L     = 5'd1;
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || out !== 32'h0) begin
            errors++; $display("FAIL reset_wins: got busy=%b out=%h want 0 0", busy, out);
        end
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
    endtask

`ifdef SHL_OVF_EN
    task automatic test_ovf();
        int n;
        logic [31:0] vd  [4];
        logic [4:0]  vl  [4];
        logic        vo  [4];
        logic [31:0] vr  [4];
        vd[0] = 32'h4000_0000; vl[0] = 5'd1;  vo[0] = 1'b1; vr[0] = 32'h8000_0000;
        vd[1] = 32'hC000_0000; vl[1] = 5'd1;  vo[1] = 1'b0; vr[1] = 32'h8000_0000;
        vd[2] = 32'h0000_0001; vl[2] = 5'd30; vo[2] = 1'b0; vr[2] = 32'h4000_0000;
        vd[3] = 32'h0000_0001; vl[3] = 5'd31; vo[3] = 1'b1; vr[3] = 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            start_op(vd[i], vl[i]);
            checks++;
            if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_accept[%0d]: got %b want 0", i, ovf); end
            wait_done(n);
            checks++;
            if (ovf !== vo[i] || out !== vr[i]) begin
                errors++; $display("FAIL ovf_vec[%0d]: got ovf=%b out=%h want %b %h", i, ovf, out, vo[i], vr[i]);
            end
            @(posedge clock);
            #1;
            checks++;
            if (ovf !== vo[i]) begin errors++; $display("FAIL ovf_hold[%0d]: got %b want %b", i, ovf, vo[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_and_discard();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_shift();
        test_reset_vs_start();
`ifdef SHL_OVF_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
